// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared conv-layer frame sizes and controller state encoding
package conv_layer_pkg;

  // Layer-1 frame geometry: 96x96 input map, 88x88 result map.
  localparam int CONV1_IN_LEN  = 9216;
  localparam int CONV1_OUT_LEN = 7744;
  // Samples pushed into the engine line buffer before it is enabled.
  localparam int CONV1_PREFILL = 864;
  // Cycles to wait for outstanding results once the input stream has ended.
  localparam int CONV1_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } conv_state_e;

endpackage

// File: rtl/conv_frame_cnt.sv
// rtl/conv_frame_cnt.sv - saturating frame counter with synchronous clear
module conv_frame_cnt #(
  parameter int WIDTH = 14,
  parameter int MAX   = 9216
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Count up on inc, hold at MAX so a late event can never wrap to zero.
  always_ff @(posedge clk_in) begin
    if (rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_1_ctrl.sv
// rtl/conv_1_ctrl.sv - layer-1 convolution frame controller
module conv_1_ctrl
  import conv_layer_pkg::*;
#(
  parameter int IN_LEN  = CONV1_IN_LEN,
  parameter int OUT_LEN = CONV1_OUT_LEN,
  parameter int PREFILL = CONV1_PREFILL,
  parameter int TIMEOUT = CONV1_TIMEOUT
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        in_rd_en,
  output logic [13:0] in_rd_addr,
  input  logic [15:0] in_rd_data,
  output logic        conv_rst,
  output logic        conv_start,
  output logic [15:0] conv_map_in,
  input  logic [15:0] conv_map_out,
  input  logic        conv_save,
  input  logic        conv_ready,
  output logic        out_wr_en,
  output logic [12:0] out_wr_addr,
  output logic [15:0] out_wr_data
);

  localparam logic [13:0] RD_END   = 14'(IN_LEN);
  localparam logic [13:0] IN_LAST  = 14'(IN_LEN - 1);
  localparam logic [13:0] PRE_LAST = 14'(PREFILL - 1);
  localparam logic [12:0] WR_END   = 13'(OUT_LEN);
  localparam logic [12:0] WR_LAST  = 13'(OUT_LEN - 1);
  localparam logic [10:0] TO_LAST  = 11'(TIMEOUT - 1);

  conv_state_e state_q, state_d;

  logic [13:0] rd_cnt;
  logic [13:0] smp_cnt;
  logic [12:0] wr_cnt;
  logic [10:0] to_cnt;

  logic rd_valid_q;
  logic ready_q;
  logic err_q;

  logic busy_st;
  logic frame_clr;
  logic rd_inc;
  logic wr_ok;
  logic wr_drop;
  logic wr_last;
  logic to_hit;
  logic ready_fall;

  assign busy_st   = (state_q == ST_PREFILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_clr = (state_q == ST_IDLE) && go;
  assign rd_inc    = ((state_q == ST_PREFILL) || (state_q == ST_RUN)) && (rd_cnt != RD_END);

  // Results are written straight through; once the frame is full any extra one is discarded.
  assign wr_ok      = conv_save && (wr_cnt != WR_END) && !rst_n;
  assign wr_drop    = conv_save && (wr_cnt == WR_END);
  assign wr_last    = wr_ok && (wr_cnt == WR_LAST);
  assign to_hit     = (state_q == ST_DRAIN) && (to_cnt == TO_LAST);
  // Engine claiming completion with results still owed is an error, but the frame carries on.
  assign ready_fall = busy_st && ready_q && !conv_ready && (wr_cnt < WR_LAST);

  assign in_rd_addr  = rd_cnt;
  assign conv_map_in = (rd_valid_q && (state_q != ST_DRAIN)) ? in_rd_data : 16'h0000;
  assign out_wr_en   = wr_ok;
  assign out_wr_addr = wr_cnt;
  assign out_wr_data = conv_map_out;
  assign err         = err_q;

  conv_frame_cnt #(.WIDTH(14), .MAX(IN_LEN)) u_rd_cnt (
    .clk_in (clk_in), .rst_n (rst_n), .clr (frame_clr), .inc (rd_inc), .cnt (rd_cnt)
  );

  conv_frame_cnt #(.WIDTH(14), .MAX(IN_LEN)) u_smp_cnt (
    .clk_in (clk_in), .rst_n (rst_n), .clr (frame_clr), .inc (rd_valid_q), .cnt (smp_cnt)
  );

  conv_frame_cnt #(.WIDTH(13), .MAX(OUT_LEN)) u_wr_cnt (
    .clk_in (clk_in), .rst_n (rst_n), .clr (frame_clr), .inc (wr_ok), .cnt (wr_cnt)
  );

  conv_frame_cnt #(.WIDTH(11), .MAX(TIMEOUT)) u_to_cnt (
    .clk_in (clk_in), .rst_n (rst_n), .clr (frame_clr), .inc (state_q == ST_DRAIN), .cnt (to_cnt)
  );

  // State register, one-cycle RAM read latency tracker and conv_ready history.
  always_ff @(posedge clk_in) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_inc;
      ready_q    <= conv_ready;
    end
  end

  // Sticky error, cleared only when a new frame is accepted.
  always_ff @(posedge clk_in) begin
    if (rst_n) begin
      err_q <= 1'b0;
    end else if (frame_clr) begin
      err_q <= 1'b0;
    end else if (wr_drop || ready_fall || (to_hit && !wr_last)) begin
      err_q <= 1'b1;
    end
  end

  // Next state and per-state engine/RAM controls; a full result frame always ends the run.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    conv_rst   = 1'b1;
    conv_start = 1'b0;
    in_rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        busy     = 1'b1;
        conv_rst = 1'b0;
        in_rd_en = rd_inc;
        if (wr_last)                                   state_d = ST_DONE;
        else if (rd_valid_q && (smp_cnt == PRE_LAST))  state_d = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        conv_rst   = 1'b0;
        conv_start = 1'b1;
        in_rd_en   = rd_inc;
        if (wr_last)                                   state_d = ST_DONE;
        else if (rd_valid_q && (smp_cnt == IN_LAST))   state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        conv_rst   = 1'b0;
        conv_start = 1'b1;
        if (wr_last || to_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_1_ctrl.sv
// tb/tb_conv_1_ctrl.sv - directed bench for conv_1_ctrl
module tb_conv_1_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        go;
  logic        busy, done, err;
  logic        in_rd_en;
  logic [13:0] in_rd_addr;
  logic [15:0] in_rd_data = 16'h0000;
  logic        conv_rst, conv_start;
  logic [15:0] conv_map_in, conv_map_out;
  logic        conv_save, conv_ready;
  logic        out_wr_en;
  logic [12:0] out_wr_addr;
  logic [15:0] out_wr_data;

  int total = 0;
  int bad   = 0;

  // conv engine model state
  int   m_run   = 0;
  int   m_saves = 0;
  int   m_n     = 0;
  int   m_drop  = 32'h4000_0000;
  logic m_clr   = 1'b1;

  // monitor state
  logic        mon_on = 1'b0;
  int          cyc, rd_exp, rd_bad, map_bad, wr_exp, wr_bad, start_cyc, done_cnt, done_cyc;
  logic        prev_en;
  logic [13:0] prev_addr;
  logic [15:0] exp_map;

  always #5 clk_in = ~clk_in;

  conv_1_ctrl dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .in_rd_en     (in_rd_en),
    .in_rd_addr   (in_rd_addr),
    .in_rd_data   (in_rd_data),
    .conv_rst     (conv_rst),
    .conv_start   (conv_start),
    .conv_map_in  (conv_map_in),
    .conv_map_out (conv_map_out),
    .conv_save    (conv_save),
    .conv_ready   (conv_ready),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data)
  );

  // input RAM: data equals address, one cycle latency
  always @(posedge clk_in) if (in_rd_en) in_rd_data <= {2'b00, in_rd_addr};

  // conv engine: results begin 1000 enabled cycles after conv_start, one per cycle
  assign conv_save    = (m_run >= 1000) && (m_saves < m_n);
  assign conv_ready   = !conv_rst && (m_saves < m_n) && (m_saves < m_drop);
  assign conv_map_out = 16'(m_saves) ^ 16'hA5C3;

  always @(posedge clk_in) begin
    if (m_clr) begin
      m_run   <= 0;
      m_saves <= 0;
    end else begin
      if (conv_start) m_run <= m_run + 1;
      if (conv_save)  m_saves <= m_saves + 1;
    end
  end

  always @(negedge clk_in) begin
    if (mon_on) begin
      if (in_rd_en) begin
        if (in_rd_addr != 14'(rd_exp)) rd_bad++;
        rd_exp++;
      end
      exp_map = prev_en ? {2'b00, prev_addr} : 16'h0000;
      if (conv_map_in != exp_map) map_bad++;
      prev_en   = in_rd_en;
      prev_addr = in_rd_addr;
      if (out_wr_en) begin
        if ((out_wr_addr != 13'(wr_exp)) || (out_wr_data != (16'(wr_exp) ^ 16'hA5C3))) wr_bad++;
        wr_exp++;
      end
      if (conv_start && (start_cyc < 0)) start_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cyc++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_frame(input int n_saves, input int drop_at, input int go_at,
                           input int rst_at, input int limit);
    m_n    = n_saves;
    m_drop = drop_at;
    m_clr  = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    m_clr = 1'b0;
    go    = 1'b1;
    @(posedge clk_in); #1;
    go        = 1'b0;
    cyc       = 0;
    rd_exp    = 0;
    rd_bad    = 0;
    map_bad   = 0;
    wr_exp    = 0;
    wr_bad    = 0;
    start_cyc = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    prev_en   = 1'b0;
    prev_addr = 14'd0;
    mon_on    = 1'b1;
    while ((done_cnt == 0) && (cyc < limit) && !((rst_at > 0) && (cyc == rst_at))) begin
      go = ((go_at > 0) && (cyc == go_at)) ? 1'b1 : 1'b0;
      @(posedge clk_in); #1;
    end
    go = 1'b0;
    if (rst_at == 0) begin
      repeat (20) @(posedge clk_in);
      #1;
      mon_on = 1'b0;
    end
  endtask

  task automatic frame_checks(input string name, input int exp_wr, input int exp_err);
    chk({name, " reads"},       rd_exp,    9216);
    chk({name, " rd_addr seq"}, rd_bad,    0);
    chk({name, " map_in"},      map_bad,   0);
    chk({name, " writes"},      wr_exp,    exp_wr);
    chk({name, " wr addr/data"}, wr_bad,   0);
    chk({name, " start cycle"}, start_cyc, 865);
    chk({name, " done count"},  done_cnt,  1);
    chk({name, " err"},         int'(err), exp_err);
    chk({name, " busy after"},  int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    go    = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset busy",       int'(busy),       0);
    chk("reset done",       int'(done),       0);
    chk("reset err",        int'(err),        0);
    chk("reset in_rd_en",   int'(in_rd_en),   0);
    chk("reset in_rd_addr", int'(in_rd_addr), 0);
    chk("reset conv_start", int'(conv_start), 0);
    chk("reset conv_rst",   int'(conv_rst),   1);
    chk("reset map_in",     int'(conv_map_in), 0);
    chk("reset wr_en",      int'(out_wr_en),  0);
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("idle busy", int'(busy), 0);

    // nominal frame
    run_frame(7744, 32'h4000_0000, 0, 0, 12000);
    frame_checks("nominal", 7744, 0);

    // go while busy is ignored
    run_frame(7744, 32'h4000_0000, 100, 0, 12000);
    frame_checks("go busy", 7744, 0);

    // engine stalls after 7000 results: drain timeout
    run_frame(7000, 32'h4000_0000, 0, 0, 12000);
    frame_checks("timeout", 7000, 1);
    chk("timeout done cycle", done_cyc, 10241);

    // one result too many is dropped
    run_frame(7745, 32'h4000_0000, 0, 0, 12000);
    frame_checks("overflow", 7744, 1);

    // reset mid-run
    run_frame(7744, 32'h4000_0000, 0, 3000, 12000);
    chk("abort reached", cyc, 3000);
    rst_n = 1'b1;
    m_clr = 1'b1;
    #1;
    chk("abort save seen", int'(conv_save), 1);
    chk("abort wr forced", int'(out_wr_en), 0);
    @(posedge clk_in); #1;
    rst_n = 1'b0;
    chk("abort busy",       int'(busy),       0);
    chk("abort conv_rst",   int'(conv_rst),   1);
    chk("abort in_rd_en",   int'(in_rd_en),   0);
    chk("abort in_rd_addr", int'(in_rd_addr), 0);
    chk("abort conv_start", int'(conv_start), 0);
    repeat (20) @(posedge clk_in);
    #1;
    mon_on = 1'b0;
    chk("abort no done", done_cnt, 0);
    run_frame(7744, 32'h4000_0000, 0, 0, 12000);
    frame_checks("after abort", 7744, 0);

    // conv_ready drops early
    run_frame(7744, 5000, 0, 0, 12000);
    frame_checks("ready drop", 7744, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_1_ctrl.md
CONV_1_CTRL -- requirements
Module: conv_1_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clk_in and rst_n (rst_n=1 means reset despite the name).
REQ-002 Parameters, one per line (name, default, meaning):
  IN_LEN, 9216, input-map samples streamed per frame (96x96)
  OUT_LEN, 7744, conv results expected per frame (88x88)
  PREFILL, 864, samples delivered before conv_start asserts (conv line-buffer depth)
  TIMEOUT, 1024, cycles allowed after last input sample before abort
REQ-003 Ports, one per line (name, direction, width, meaning):
  clk_in  in  1  clock
  rst_n  in  1  synchronous active-high reset
  go  in  1  frame start request, sampled in IDLE only
  busy  out  1  high from go acceptance until done
  done  out  1  one-cycle pulse at frame end
  err  out  1  sticky error flag, cleared by the next accepted go
  in_rd_en  out  1  input-map RAM read enable
  in_rd_addr  out  14  input-map RAM address
  in_rd_data  in  16  input-map RAM data, valid 1 cycle after in_rd_en
  conv_rst  out  1  active-high reset to conv engine
  conv_start  out  1  conv engine enable
  conv_map_in  out  16  signed sample to conv engine
  conv_map_out  in  16  signed conv result
  conv_save  in  1  conv result valid
  conv_ready  in  1  conv engine not yet complete
  out_wr_en  out  1  output RAM write enable
  out_wr_addr  out  13  output RAM address
  out_wr_data  out  16  output RAM data

Function
REQ-004 FSM states SHALL be IDLE, PREFILL, RUN, DRAIN, DONE.
REQ-005 IDLE: conv_rst=1, conv_start=0, busy=0, in_rd_en=0; go=1 -> PREFILL next cycle, clear err, read/write/sample counters to 0.
REQ-006 PREFILL/RUN: in_rd_en=1 and in_rd_addr increments by 1 per cycle from 0 until IN_LEN addresses issued; no stall.
REQ-007 conv_map_in SHALL equal in_rd_data in the cycle after each read, and 0 otherwise.
REQ-008 conv_rst SHALL be 0 in PREFILL, RUN, DRAIN; the sample counter increments on every cycle conv_map_in carries read data.
REQ-009 PREFILL -> RUN when the sample counter reaches PREFILL; conv_start SHALL be 1 throughout RUN and DRAIN.
REQ-010 RUN -> DRAIN when the sample counter reaches IN_LEN; in DRAIN conv_map_in=0 and a timeout counter increments each cycle.
REQ-011 In any state, conv_save=1 SHALL produce out_wr_en=1, out_wr_data=conv_map_out, out_wr_addr=write counter, same cycle (combinational pass-through), then write counter +1.
REQ-012 Write counter reaching OUT_LEN (after the write) -> DONE; conv_save while counter already at OUT_LEN SHALL be dropped and set err.
REQ-013 DRAIN timeout reaching TIMEOUT before OUT_LEN writes -> DONE with err=1.
REQ-014 conv_ready falling while write counter < OUT_LEN-1 SHALL set err (no state change).
REQ-015 DONE: one cycle, done=1, conv_start=0, busy=0, then IDLE; go in DONE is ignored.
REQ-016 go outside IDLE SHALL be ignored; simultaneous go and rst_n: reset wins.
REQ-017 busy=1 in PREFILL, RUN, DRAIN.

Reset
REQ-018 rst_n=1 at any time SHALL force IDLE next edge: busy=0, done=0, err=0, in_rd_en=0, in_rd_addr=0, conv_start=0, conv_rst=1, conv_map_in=0, out_wr_en forced 0, all counters 0; a frame in progress is abandoned.

Structure
REQ-019 IN_LEN, OUT_LEN, PREFILL, TIMEOUT defaults and the state encoding SHALL live in a shared conv-layer package reused by later layer controllers.
REQ-020 The block SHALL be flat, with one optional sub-module conv_frame_cnt (parameterized saturating counter) instantiated for read, sample, write and timeout counters.

Verification
REQ-021 Nominal: go pulse, RAM model data=addr, conv model asserting save 7744 times -> in_rd_addr 0..9215 once each, conv_start rises exactly 865 cycles after go, done pulse once, out_wr_addr 0..7743, err=0.
REQ-022 Go while busy at cycle 100 -> no restart, in_rd_addr sequence unbroken, single done.
REQ-023 Conv model stops after 7000 saves -> DONE 1024 cycles after sample 9216, err=1, busy=0.
REQ-024 Conv model issues 7745 saves -> 7744 writes only, err=1.
REQ-025 rst_n=1 for one cycle mid-RUN (cycle 3000) -> next cycle IDLE, conv_rst=1, in_rd_en=0, no done; a following go runs a clean frame with err=0.
REQ-026 conv_ready dropped at write 5000 -> err=1, frame still completes at 7744 writes with done pulse.
